// File: rtl/pe_oa_compressor.sv
// pe_oa_compressor: runs the PE start/finish handshake, captures the dense OA tile and streams it
// as compressed per-row (value, channel) beats. Define OA_RELU_EN to clamp negatives to 0 at capture.
module pe_oa_compressor #(
  parameter int ROW     = 4,
  parameter int CHANNEL = 8,
  parameter int DATA_BW = 8,
  parameter int C_BW    = 3
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_go,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_pe_start,
  input  logic                              i_pe_finish,
  input  logic [ROW*CHANNEL*DATA_BW-1:0]    i_pe_oa,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic signed [DATA_BW-1:0]         o_data,
  output logic [C_BW-1:0]                   o_c_idx,
  output logic [$clog2(ROW)-1:0]            o_row,
  output logic                              o_eor,
  output logic                              o_empty_row,
  output logic [$clog2(CHANNEL):0]          o_row_len,
  output logic [$clog2(ROW*CHANNEL):0]      o_nnz_total
);
  localparam int R_BW   = $clog2(ROW);
  localparam int LEN_BW = $clog2(CHANNEL) + 1;

  typedef enum logic [1:0] {IDLE, REQ, SCAN, RELEASE} state_t;

  state_t state, state_nxt;

  logic signed [DATA_BW-1:0] cap    [ROW][CHANNEL];
  logic signed [DATA_BW-1:0] cap_in [ROW][CHANNEL];
  logic [CHANNEL-1:0]        mask    [ROW];
  logic [CHANNEL-1:0]        mask_in [ROW];

  logic [R_BW-1:0]    row_ptr;
  logic [C_BW-1:0]    ch_ptr;
  logic               scan_end;
  logic [CHANNEL-1:0] cur_mask, remain;
  logic [C_BW-1:0]    next_ch;
  logic               beat_eor, accept, load, capture;

  function automatic logic [C_BW-1:0] lowest_set(input logic [CHANNEL-1:0] m);
    lowest_set = '0;
    for (int i = CHANNEL - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = C_BW'(i);
    end
  endfunction

  function automatic logic [LEN_BW-1:0] popcount(input logic [CHANNEL-1:0] m);
    popcount = '0;
    for (int i = 0; i < CHANNEL; i++) popcount = popcount + LEN_BW'(m[i]);
  endfunction

  // Unpack the PE array, optionally clamp negatives, and derive the per-row nonzero masks.
  always_comb begin
    for (int r = 0; r < ROW; r++) begin
      mask_in[r] = '0;
      for (int c = 0; c < CHANNEL; c++) begin
        cap_in[r][c] = i_pe_oa[(r*CHANNEL+c)*DATA_BW +: DATA_BW];
`ifdef OA_RELU_EN
        if (cap_in[r][c][DATA_BW-1]) cap_in[r][c] = '0;
`endif
        mask_in[r][c] = |cap_in[r][c];
      end
    end
  end

  // NOTE: every signal this block writes gets a default first, so no path can infer a latch.
  always_comb begin
    cur_mask  = mask[row_ptr];
    remain    = cur_mask & ({CHANNEL{1'b1}} << ch_ptr);
    next_ch   = lowest_set(remain);
    beat_eor  = ~|(remain & ~(CHANNEL'(1) << next_ch));
    accept    = o_valid & i_ready;
    load      = (state == SCAN) && (!o_valid || i_ready) && !scan_end;
    capture   = (state == REQ) && i_pe_finish;
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_go) state_nxt = REQ;
      REQ:     if (i_pe_finish) state_nxt = SCAN;
      SCAN:    if (accept && scan_end) state_nxt = RELEASE;
      RELEASE: if (!i_pe_finish) state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the capture array is reset too, so an aborted tile leaves no stale data behind.
      for (int r = 0; r < ROW; r++) begin
        mask[r] <= '0;
        for (int c = 0; c < CHANNEL; c++) cap[r][c] <= '0;
      end
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pe_start  <= 1'b0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_c_idx     <= '0;
      o_row       <= '0;
      o_eor       <= 1'b0;
      o_empty_row <= 1'b0;
      o_row_len   <= '0;
      o_nnz_total <= '0;
      row_ptr     <= '0;
      ch_ptr      <= '0;
      scan_end    <= 1'b0;
    end else begin
      o_busy     <= (state_nxt != IDLE);
      o_pe_start <= (state_nxt == REQ);
      o_done     <= (state == RELEASE) && !i_pe_finish;

      if (capture) begin
        cap         <= cap_in;
        mask        <= mask_in;
        o_nnz_total <= '0;
        row_ptr     <= '0;
        ch_ptr      <= '0;
        scan_end    <= 1'b0;
      end

      if (accept && !o_empty_row) o_nnz_total <= o_nnz_total + 1'b1;

      if (load) begin
        o_valid     <= 1'b1;
        o_data      <= (|remain) ? cap[row_ptr][next_ch] : '0;
        o_c_idx     <= (|remain) ? next_ch : '0;
        o_row       <= row_ptr;
        o_eor       <= beat_eor;
        o_empty_row <= ~|remain;
        o_row_len   <= popcount(cur_mask);
        if (beat_eor) begin
          ch_ptr <= '0;
          // The last row parks the pointer and flags end-of-tile instead of wrapping.
          if (row_ptr == R_BW'(ROW - 1)) scan_end <= 1'b1;
          else                           row_ptr  <= row_ptr + 1'b1;
        end else begin
          ch_ptr <= next_ch + 1'b1;
        end
      end else if (accept) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pe_oa_compressor.md
Name: pe_oa_compressor

Overview:
- Initiator-side partner of the PE. Drives the PE's level i_start / o_finish handshake and captures the dense output-activation array (ROW*CHANNEL signed words) when the PE finishes.
- Re-encodes the captured array into the compressed IA format the PE consumes: nonzero data plus channel index, one row at a time, with per-row length.
- Sits between a PE and the IA buffer of the next layer. Output is a valid/ready beat stream.

Parameters:
ROW, 4, output rows per tile
CHANNEL, 8, channels per row
DATA_BW, 8, signed activation width
C_BW, 3, channel index width; equals $clog2(CHANNEL)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_go  in  1  start one tile; sampled only in IDLE
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse at end of tile
o_pe_start  out  1  to PE i_start
i_pe_finish  in  1  from PE o_finish
i_pe_oa  in  ROW*CHANNEL*DATA_BW  PE o_OA flattened; element k = row*CHANNEL+ch at bits [k*DATA_BW +: DATA_BW]
o_valid  out  1  beat valid
i_ready  in  1  downstream accept
o_data  out  DATA_BW  signed nonzero value; 0 on empty-row beat
o_c_idx  out  C_BW  channel index; 0 on empty-row beat
o_row  out  $clog2(ROW)  row of beat
o_eor  out  1  last beat of row
o_empty_row  out  1  row has no nonzeros; beat carries eor=1
o_row_len  out  $clog2(CHANNEL)+1  nonzero count of o_row; meaningful when o_eor=1
o_nnz_total  out  $clog2(ROW*CHANNEL)+1  tile nonzero count; meaningful when o_done=1

Behaviour:
- Reset: state IDLE. All outputs 0. Capture registers, nonzero masks and counters cleared. Reset takes effect mid-tile too, with no further beats emitted.
- States: IDLE -> REQ -> SCAN -> RELEASE -> IDLE. All outputs are registered.
- IDLE:
  - i_go=1 -> REQ. o_pe_start=1 from the next cycle, so i_go at cycle 0 gives start high at cycle 1.
  - i_go is ignored in any other state.
- REQ:
  - o_pe_start is held at 1.
  - On the first cycle i_pe_finish=1: latch all of i_pe_oa, build a per-row nonzero mask, clear o_nnz_total, go to SCAN.
  - o_pe_start falls in the cycle after finish is seen.
  - There is no timeout.
- SCAN:
  - Pointer (row, ch). For the current row, the next channel is the lowest set mask bit >= ch, found by a priority encoder. Zeros are skipped in zero cycles, giving one beat per cycle at full throughput.
  - A beat loads when o_valid=0, or when o_valid=1 and i_ready=1.
  - All beat fields stay stable while o_valid=1 and i_ready=0.
  - o_eor=1 when no mask bit is above the current channel.
  - A row with an empty mask emits exactly one beat: o_empty_row=1, o_eor=1, o_row_len=0.
  - o_row_len is the popcount of the row mask.
  - o_nnz_total increments on each accepted non-empty beat.
  - After the last row's eor beat is accepted, o_valid drops and the block goes to RELEASE.
- RELEASE:
  - Wait until i_pe_finish=0, i.e. the PE has returned to idle.
  - Then pulse o_done for one cycle, go to IDLE, and o_busy falls with the transition.
- Edge cases:
  - If finish is already low on entry to RELEASE, o_done pulses on the next cycle.
  - Minimum beats per tile is ROW; maximum is ROW*CHANNEL.
  - Row counter advances from ROW-1 to end-of-tile; it never wraps to 0 within a tile.

Optional Feature:
OA_RELU_EN:
- Defined: at capture, negative words are clamped to 0 before mask build. They are never emitted and do not count toward o_row_len or o_nnz_total.
- Undefined: every nonzero signed word, positive or negative, is emitted unchanged.

Test Plan:
All scenarios use ROW=4, CHANNEL=8, DATA_BW=8.
- All-zero OA, i_ready=1 -> four beats, rows 0..3, each with empty_row=1, eor=1, len=0; o_nnz_total=0 at o_done.
- Row0 ch2=5, ch7=-3 (0xFD), rest zero, i_ready=1:
  - without OA_RELU_EN -> beats (r0,c2,5,eor0), (r0,c7,0xFD,eor1,len2), then rows 1-3 empty; nnz=2.
  - with OA_RELU_EN -> single beat (r0,c2,5,eor1,len1); nnz=1.
- Dense OA, values 1..32, i_ready=1 -> 32 beats on consecutive cycles, eor on ch7 of each row, len=8 each, nnz=32.
- Backpressure: i_ready=0 for 3 cycles while the first beat (r0,c2,5) is valid -> all fields unchanged for those cycles; the next beat appears one cycle after ready rises.
- Handshake: PE finish rises 5 cycles after o_pe_start; o_pe_start falls 1 cycle after finish is seen; finish held high 4 extra cycles after scan ends -> o_done fires exactly 1 cycle after finish falls.
- Reset asserted mid-SCAN after 2 beats -> all outputs 0 immediately. A later i_go runs a full correct tile from row 0.
